fifo_reg_nb: RTL

Parametrised synchronous FIFO built from enable-gated dff storage words. It is the generalised successor of the fixed 4-bit write-enabled register and buffers WIDTH-bit words between pipeline stages, for example fetch-to-decode instruction buffering and store queues. Read is first-word-fall-through: the oldest entry is always visible on `outData` when the FIFO is not empty.

---
 rtl/fifo_reg_nb.sv | 97 +++++++++
 1 files changed

// File: rtl/fifo_reg_nb.sv
// Parametrised synchronous FIFO with first-word-fall-through read.
// Storage is DEPTH enable-gated register words; full/empty are decoded from the entry count.

module fifo_reg_nb_word #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

module fifo_reg_nb #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] inData,
    input  logic             wrEn,
    input  logic             rdEn,
    output logic [WIDTH-1:0] outData,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count,
    output logic             err
);

    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      count_r;
    logic             err_r;
    logic             push_ok;
    logic             pop_ok;
    logic [WIDTH-1:0] words [DEPTH];

    assign full  = (count_r == CNT_MAX);
    assign empty = (count_r == '0);

    // A read frees a slot in the same cycle, so a full FIFO can still take a write.
    assign push_ok = wrEn & (~full | rdEn);
    assign pop_ok  = rdEn & ~empty;

    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        localparam logic [AW-1:0] IDX = AW'(i);
        fifo_reg_nb_word #(.WIDTH(WIDTH)) u_word (
            .clk (clk),
            .rst (rst),
            .en  (push_ok && (wptr == IDX)),
            .d   (inData),
            .q   (words[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            count_r <= '0;
            err_r   <= 1'b0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + PTR_ONE;
            end
            if (pop_ok) begin
                rptr <= rptr + PTR_ONE;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
            err_r <= (wrEn & ~push_ok) | (rdEn & ~pop_ok);
        end
    end

    assign outData = empty ? '0 : words[rptr];
    assign count   = count_r;
    assign err     = err_r;

endmodule
